ram_8x256_writer: RTL and testbench
===================================

RAM_8X256_WRITER -- requirements
Module: ram_8x256_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: single-cycle request to begin a fill burst.
REQ-004 SHALL have port base, input, 8 bits: first RAM address of the burst; sampled when start is accepted.
REQ-005 SHALL have port len, input, 9 bits: number of bytes in the burst (legal range 1..256); sampled when start is accepted.
REQ-006 SHALL have port abort, input, 1 bit: terminates an active burst.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-008 SHALL have port in_data, input, 8 bits: stream byte.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a byte this cycle.
REQ-010 SHALL have port we, output, 1 bit: RAM write enable.
REQ-011 SHALL have port waddr, output, 8 bits: RAM write address.
REQ-012 SHALL have port wdata, output, 8 bits: RAM write data.
REQ-013 SHALL have port busy, output, 1 bit: a burst is active.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal start.
REQ-016 SHALL have port cnt, output, 9 bits: bytes written in the current or last burst.

Function
REQ-017 FSM SHALL have states IDLE, FILL, FIN.
REQ-018 IDLE + start with len in 1..256 SHALL perform all of: latch base into the address pointer, latch len, clear cnt, go to FILL.
REQ-019 IDLE + start with len=0 or len>256 SHALL pulse err for 1 cycle and stay in IDLE; cnt SHALL be unchanged.
REQ-020 start while in FILL or FIN SHALL be ignored, with no err.
REQ-021 in_ready SHALL be 1 only in FILL; it SHALL be combinational from state only, not from in_valid.
REQ-022 Accept SHALL be defined as in_valid=1 and in_ready=1 on a clock edge.
REQ-023 Each accept SHALL drive, on the next cycle, we=1, waddr=pointer, wdata=in_data (1-cycle registered latency).
REQ-024 Each accept SHALL increment the pointer modulo 256 (0xFF wraps to 0x00) and increment cnt by 1.
REQ-025 Cycles without an accept SHALL drive we=0; waddr and wdata SHALL hold their last values.
REQ-026 The accept that makes cnt equal len SHALL move the FSM to FIN; in_ready SHALL be 0 from the next cycle.
REQ-027 FIN SHALL pulse done=1 for exactly 1 cycle, coincident with the final we=1, then return to IDLE.
REQ-028 busy SHALL be 1 in FILL and FIN, and 0 in IDLE.
REQ-029 abort in FILL SHALL return the FSM to IDLE next cycle, with no done pulse.
REQ-030 When abort coincides with an accept, that accepted byte SHALL still be written.
REQ-031 After an abort, cnt SHALL hold the count of bytes written, including any byte accepted on the abort cycle.
REQ-032 abort in IDLE or FIN SHALL have no effect; abort SHALL take priority over completion only in FILL.
REQ-033 len=256 SHALL write every address exactly once, wrapping through 0x00 when base is not 0.
REQ-034 cnt SHALL hold its value in IDLE until the next accepted start clears it.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force the FSM to IDLE in any state, including mid-burst, with no done pulse.
REQ-036 Under reset, the pointer, waddr, wdata and cnt SHALL be 0.
REQ-037 Under reset, we, in_ready, busy, done and err SHALL be 0.
REQ-038 The first start SHALL be honoured on the first edge on which rst_n=1.

Verification
REQ-039 Basic burst: base=0x10, len=4, in_valid held 1, data A0..A3 -> we on 4 consecutive cycles; waddr 0x10..0x13, wdata A0..A3; done with the 4th we; cnt=4; busy then falls.
REQ-040 Wrap: base=0xFE, len=4 -> waddr sequence FE, FF, 00, 01; done once.
REQ-041 Stalls and full burst: base=0x00, len=256, in_valid toggled 1/0 -> exactly 256 we pulses, all addresses written once, done once, cnt=256.
REQ-042 Illegal length: start with len=0, then separately with len=300 -> err pulse each time; busy stays 0; no we.
REQ-043 Abort: abort on the same edge as the 3rd accept of a len=8 burst -> 3 we pulses, no done, cnt=3, IDLE next cycle.
REQ-044 Reset mid-burst: rst_n=0 after 2 accepts -> all outputs 0 next cycle; a new start after release behaves as in REQ-039.

Source files
------------

// File: rtl/ram_8x256_writer.sv
// Stream-to-RAM burst writer: fills len bytes starting at base,
// with 1-cycle registered write latency and abort/error handling.
module ram_8x256_writer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] base,
    input  logic [8:0] len,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       we,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [8:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] ptr;
    logic [8:0] len_q;
    logic       len_ok;
    logic       accept;
    logic       last;
    logic       launch;

    assign len_ok = (len != 9'd0) && (len <= 9'd256);
    assign accept = in_valid && in_ready;
    assign last   = (cnt + 9'd1) == len_q;
    assign launch = (state == IDLE) && start && len_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks completion while filling
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && len_ok) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= 8'd0;
            len_q <= 9'd0;
            cnt   <= 9'd0;
            we    <= 1'b0;
            waddr <= 8'd0;
            wdata <= 8'd0;
            err   <= 1'b0;
        end else begin
            we  <= accept;
            err <= (state == IDLE) && start && !len_ok;
            if (launch) begin
                ptr   <= base;
                len_q <= len;
                cnt   <= 9'd0;
            end else if (accept) begin
                waddr <= ptr;
                wdata <= in_data;
                ptr   <= ptr + 8'd1;
                cnt   <= cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_8x256_writer.sv
// Directed bench for ram_8x256_writer: cycle model plus a write
// scoreboard queue, checked with immediate assertions.
module tb_ram_8x256_writer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base;
    logic [8:0] len;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] cnt;

    ram_8x256_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int         m_state;
    logic [7:0] m_ptr;
    logic [8:0] m_len;
    logic [8:0] m_cnt;
    logic       m_we;
    logic [7:0] m_waddr;
    logic [7:0] m_wdata;
    logic       m_err;
    logic [15:0] sb[$];

    int we_n;
    int done_n;
    int err_n;
    int hits[256];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [7:0] b,
                       input logic [8:0] l, input logic a, input logic v,
                       input logic [7:0] d);
        logic        acc;
        logic [15:0] e;
        rst_n = r; start = s; base = b; len = l;
        abort = a; in_valid = v; in_data = d;
        @(posedge clk);
        acc = (m_state == 1) && v;
        if (!r) begin
            m_state = 0; m_ptr = 0; m_len = 0; m_cnt = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        end else begin
            m_we  = acc;
            m_err = (m_state == 0) && s && (l == 0 || l > 9'd256);
            if (acc) begin
                sb.push_back({m_ptr, d});
                m_waddr = m_ptr;
                m_wdata = d;
                m_ptr   = m_ptr + 8'd1;
                m_cnt   = m_cnt + 9'd1;
            end
            case (m_state)
                0: if (s && l != 0 && l <= 9'd256) begin
                    m_state = 1; m_ptr = b; m_len = l; m_cnt = 0;
                end
                1: if (a) m_state = 0;
                   else if (acc && m_cnt == m_len) m_state = 2;
                default: m_state = 0;
            endcase
        end
        @(negedge clk);
        chk("we", we, m_we);
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("in_ready", in_ready, m_state == 1);
        chk("busy", busy, m_state != 0);
        chk("done", done, m_state == 2);
        chk("err", err, m_err);
        chk("cnt", cnt, m_cnt);
        if (we === 1'b1) begin
            we_n++;
            hits[waddr]++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_waddr", waddr, e[15:8]);
                chk("sb_wdata", wdata, e[7:0]);
            end
        end
        if (done === 1'b1) done_n++;
        if (err === 1'b1) err_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clr();
        we_n = 0; done_n = 0; err_n = 0;
        for (int i = 0; i < 256; i++) hits[i] = 0;
    endtask

    task automatic basic_burst();
        logic [7:0] seq_addr[4];
        clr();
        cyc(1, 1, 8'h10, 9'd4, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 8'hA0 + 8'(i));
            seq_addr[i] = waddr;
            chk("basic_wdata", wdata, 8'hA0 + 8'(i));
            chk("basic_waddr", seq_addr[i], 8'h10 + 8'(i));
        end
        chk("basic_done_last", done, 1);
        idle(2);
        chk("basic_we_n", we_n, 4);
        chk("basic_done_n", done_n, 1);
        chk("basic_cnt", cnt, 9'd4);
        chk("basic_busy", busy, 0);
    endtask

    initial begin
        int bad;
        m_state = 0; m_ptr = 0; m_len = 0; m_cnt = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        rst_n = 0; start = 0; base = 0; len = 0;
        abort = 0; in_valid = 0; in_data = 0;
        clr();
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h55, 9'd3, 0, 1, 8'h77);

        // first start honoured on the first released edge
        basic_burst();

        // wrap through 0x00, start during FILL ignored
        clr();
        cyc(1, 1, 8'hFE, 9'd4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 8'h11);
        chk("wrap_a0", waddr, 8'hFE);
        cyc(1, 1, 8'h40, 9'd0, 0, 1, 8'h22);
        chk("wrap_a1", waddr, 8'hFF);
        cyc(1, 0, 0, 0, 0, 1, 8'h33);
        chk("wrap_a2", waddr, 8'h00);
        cyc(1, 0, 0, 0, 0, 1, 8'h44);
        chk("wrap_a3", waddr, 8'h01);
        cyc(1, 1, 8'h40, 9'd2, 1, 0, 0);
        idle(2);
        chk("wrap_done_n", done_n, 1);
        chk("wrap_err_n", err_n, 0);
        chk("wrap_we_n", we_n, 4);

        // illegal lengths, abort in IDLE
        clr();
        cyc(1, 1, 8'h20, 9'd0, 0, 1, 8'h99);
        idle(1);
        cyc(1, 1, 8'h20, 9'd300, 1, 1, 8'h99);
        idle(2);
        chk("ill_err_n", err_n, 2);
        chk("ill_we_n", we_n, 0);
        chk("ill_cnt", cnt, 9'd4);

        // abort on the 3rd accept of a len=8 burst
        clr();
        cyc(1, 1, 8'h80, 9'd8, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 8'hC0);
        cyc(1, 0, 0, 0, 0, 0, 8'hEE);
        cyc(1, 0, 0, 0, 0, 1, 8'hC1);
        cyc(1, 0, 0, 0, 1, 1, 8'hC2);
        chk("abort_we", we, 1);
        chk("abort_busy", busy, 0);
        idle(3);
        chk("abort_we_n", we_n, 3);
        chk("abort_done_n", done_n, 0);
        chk("abort_cnt", cnt, 9'd3);

        // full 256-byte burst with stalls
        clr();
        cyc(1, 1, 8'h00, 9'd256, 0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            cyc(1, 0, 0, 0, 0, (i % 2) == 0, 8'($urandom));
        end
        idle(3);
        bad = 0;
        for (int i = 0; i < 256; i++) if (hits[i] != 1) bad++;
        chk("full_addr_once", bad, 0);
        chk("full_we_n", we_n, 256);
        chk("full_done_n", done_n, 1);
        chk("full_cnt", cnt, 9'd256);

        // reset after 2 accepts, then a clean burst
        clr();
        cyc(1, 1, 8'h30, 9'd4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 8'h01);
        cyc(1, 0, 0, 0, 0, 1, 8'h02);
        cyc(0, 0, 0, 0, 0, 1, 8'h03);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_n", done_n, 0);
        basic_burst();

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
